binary_unary_tx: RTL

- Streaming transmitter that turns a SIZE-bit binary operand into a temporal-unary (thermometer) bitstream, one bit per cycle.
- It is the producer end of the unary stream that unary_binary_MAC-style consumers count back into binary.
- It sits between a binary operand source (valid/ready) and a unary datapath (valid/ready with frame markers).
- A one-entry pending buffer lets the next operand be accepted while the current frame streams, so frames go out back-to-back.

---
 rtl/binary_unary_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/binary_unary_tx.sv
// -----------------------------------------------------------------------------
// binary_unary_tx
//
// Streaming transmitter that turns a SIZE-bit unsigned operand into a
// temporal-unary (thermometer) bitstream, one bit per beat. Ones always come
// before zeros, and the number of ones equals the operand value. Frames carry
// first/last markers so a downstream counter can rebuild the binary value.
//
// A one-entry pending buffer accepts the next operand while the current frame
// streams. When the frame ends, the next frame starts on the following cycle
// with no idle beat in between.
//
// Parameters:
//   SIZE      operand width. The default frame length is L = 2^SIZE - 1 beats.
//
// Ports:
//   clk        clock. All state changes on the rising edge.
//   reset_n    asynchronous active-low reset. It is released synchronously by
//              the reset source.
//   in_valid   an operand is present on in_data.
//   in_ready   the block can take an operand. This is !pending_full and
//              depends only on registered state.
//   in_data    unsigned binary operand.
//   out_valid  out_bit, out_first and out_last are valid.
//   out_ready  the consumer takes the current beat.
//   out_bit    unary stream bit.
//   out_first  the current beat is beat 0 of a frame.
//   out_last   the current beat is the final beat of a frame.
//
// Build option:
//   UNARY_TX_EARLY_END_EN  when defined, a frame ends on its last '1' beat.
//                          The frame length is max(value, 1), so value 0 sends
//                          one zero beat. When undefined, every frame has
//                          exactly L beats.
// -----------------------------------------------------------------------------
module binary_unary_tx #(
    parameter int SIZE = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_bit,
    output logic            out_first,
    output logic            out_last
);

    // Index of the final beat of a fixed-length frame: L-1 = 2^SIZE - 2.
    localparam logic [SIZE-1:0] LAST_BEAT = SIZE'((2 ** SIZE) - 2);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [SIZE-1:0] active_reg, active_next;
    logic [SIZE-1:0] k_reg, k_next;
    logic [SIZE-1:0] pending_reg, pending_next;
    logic            pending_full_reg, pending_full_next;
    logic            out_bit_reg, out_first_reg, out_last_reg;

    logic accept;
    logic xfer;
    logic last_cur;   // the beat on the outputs now ends its frame
    logic last_nxt;   // the beat that will be on the outputs next cycle ends its frame

`ifdef UNARY_TX_EARLY_END_EN
    // The frame ends on the last '1' beat. Value 0 still sends one beat.
    assign last_cur = (active_reg  == '0) ? (k_reg  == '0) : (k_reg  == active_reg  - SIZE'(1));
    assign last_nxt = (active_next == '0) ? (k_next == '0) : (k_next == active_next - SIZE'(1));
`else
    assign last_cur = (k_reg  == LAST_BEAT);
    assign last_nxt = (k_next == LAST_BEAT);
`endif

    assign in_ready  = !pending_full_reg;
    assign accept    = in_valid && !pending_full_reg;
    assign xfer      = (state_reg == STREAM) && out_ready;

    assign out_valid = (state_reg == STREAM);
    assign out_bit   = out_bit_reg;
    assign out_first = out_first_reg;
    assign out_last  = out_last_reg;

    always_comb begin
        state_next        = state_reg;
        active_next       = active_reg;
        k_next            = k_reg;
        pending_next      = pending_reg;
        pending_full_next = pending_full_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    active_next = in_data;
                    k_next      = '0;
                    state_next  = STREAM;
                end
            end
            STREAM: begin
                if (xfer && last_cur) begin
                    // Frame boundary: chain the next operand without a bubble
                    // if there is one. The pending value is older than
                    // in_data, so it goes first. While the buffer is full,
                    // in_ready is low, so no accept can coincide with it.
                    k_next = '0;
                    if (pending_full_reg) begin
                        active_next       = pending_reg;
                        pending_full_next = 1'b0;
                    end else if (accept) begin
                        active_next = in_data;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        k_next = k_reg + SIZE'(1);
                    end
                    if (accept) begin
                        pending_next      = in_data;
                        pending_full_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The beat outputs are registered from the next-state values. This keeps
    // them aligned with out_valid (which is the state register itself) and
    // holds them steady during backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            active_reg       <= '0;
            k_reg            <= '0;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            out_bit_reg      <= 1'b0;
            out_first_reg    <= 1'b0;
            out_last_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            active_reg       <= active_next;
            k_reg            <= k_next;
            pending_reg      <= pending_next;
            pending_full_reg <= pending_full_next;
            out_bit_reg      <= (state_next == STREAM) && (k_next < active_next);
            out_first_reg    <= (state_next == STREAM) && (k_next == '0);
            out_last_reg     <= (state_next == STREAM) && last_nxt;
        end
    end

endmodule
